// File: rtl/counter_pkg.sv
// Shared types for the multi-mode flexible counter family.
package counter_pkg;

  typedef enum logic [1:0] {
    WRAP_ONE  = 2'd0,
    WRAP_ZERO = 2'd1,
    SATURATE  = 2'd2,
    ONESHOT   = 2'd3
  } cnt_mode_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/flex_prescaler.sv
// Enable prescaler: emits one tick per (prescale_val+1) enabled cycles unless inhibited.
module flex_prescaler #(
  parameter int NUM_PS_BITS = 4
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   restart,
  input  logic                   count_enable,
  input  logic                   inhibit,
  input  logic [NUM_PS_BITS-1:0] prescale_val,
  output logic                   tick
);

  logic [NUM_PS_BITS-1:0] ps;

  assign tick = count_enable && (ps == prescale_val) && !inhibit;

  // A lowered prescale_val below ps simply lets ps wrap around before matching.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ps <= '0;
    end else if (restart) begin
      ps <= '0;
    end else if (count_enable) begin
      ps <= tick ? '0 : ps + NUM_PS_BITS'(1);
    end
  end

endmodule

// File: rtl/flex_counter_mm.sv
// Multi-mode up/down counter with parallel load, terminal-count modes and prescaled enable.
module flex_counter_mm
  import counter_pkg::*;
#(
  parameter int NUM_CNT_BITS = 4,
  parameter int NUM_PS_BITS  = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    load,
  input  logic [NUM_CNT_BITS-1:0] load_val,
  input  logic                    count_enable,
  input  logic                    dir,
  input  logic [1:0]              mode,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  input  logic [NUM_PS_BITS-1:0]  prescale_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag,
  output logic                    rollover_pulse,
  output logic                    done
);

  cnt_mode_t               mode_e;
  logic                    tick;
  logic [NUM_CNT_BITS-1:0] term;
  logic [NUM_CNT_BITS-1:0] restart_val;
  logic [NUM_CNT_BITS-1:0] count_p0;
  logic [NUM_CNT_BITS-1:0] count_nxt;
  logic                    flag_p0;
  logic                    flag_nxt;
  logic                    pulse_p0;
  logic                    pulse_nxt;
  logic                    done_p0;
  logic                    done_nxt;

  function automatic logic [NUM_CNT_BITS-1:0] step_count(
    input logic [NUM_CNT_BITS-1:0] cur,
    input logic                    down
  );
    step_count = down ? cur - NUM_CNT_BITS'(1) : cur + NUM_CNT_BITS'(1);
  endfunction

  assign mode_e = cnt_mode_t'(mode);

  flex_prescaler #(
    .NUM_PS_BITS(NUM_PS_BITS)
  ) u_prescaler (
    .clk          (clk),
    .n_rst        (n_rst),
    .restart      (clear | load),
    .count_enable (count_enable),
    .inhibit      (done_p0),
    .prescale_val (prescale_val),
    .tick         (tick)
  );

  always_comb begin
    term        = (dir == DIR_UP) ? rollover_val : '0;
    restart_val = '0;
    if (dir == DIR_DOWN) begin
      restart_val = rollover_val;
    end else if (mode_e == WRAP_ONE) begin
      restart_val = NUM_CNT_BITS'(1);
    end
  end

  always_comb begin
    count_nxt = count_p0;
    pulse_nxt = 1'b0;
    done_nxt  = done_p0;
    if (clear) begin
      count_nxt = '0;
      done_nxt  = 1'b0;
    end else if (load) begin
      count_nxt = load_val;
      done_nxt  = 1'b0;
    end else if (tick) begin
      if (count_p0 != term) begin
        count_nxt = step_count(count_p0, dir);
      end else if (mode_e == WRAP_ONE || mode_e == WRAP_ZERO) begin
        count_nxt = restart_val;
      end
      // Pulse only on arrival, so a saturated count does not re-fire.
      pulse_nxt = (count_nxt == term) && (count_p0 != term);
      if (mode_e == ONESHOT && count_nxt == term) begin
        done_nxt = 1'b1;
      end
    end
    flag_nxt = (count_nxt == term);
  end

  // Stage p0: count and flag registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_p0 <= '0;
      flag_p0  <= 1'b0;
      pulse_p0 <= 1'b0;
      done_p0  <= 1'b0;
    end else begin
      count_p0 <= count_nxt;
      flag_p0  <= flag_nxt;
      pulse_p0 <= pulse_nxt;
      done_p0  <= done_nxt;
    end
  end

  assign count_out      = count_p0;
  assign rollover_flag  = flag_p0;
  assign rollover_pulse = pulse_p0;
  assign done           = done_p0;

endmodule

// File: tb/tb_flex_counter_mm.sv
// Directed scoreboard bench for flex_counter_mm (NUM_CNT_BITS=4, NUM_PS_BITS=4).
module tb_flex_counter_mm;
  import counter_pkg::*;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       clear;
  logic       load;
  logic [3:0] load_val;
  logic       count_enable;
  logic       dir;
  logic [1:0] mode;
  logic [3:0] rollover_val;
  logic [3:0] prescale_val;
  logic [3:0] count_out;
  logic       rollover_flag;
  logic       rollover_pulse;
  logic       done;

  typedef struct {
    logic [3:0] c;
    logic       f;
    logic       p;
    logic       d;
    string      name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  flex_counter_mm #(
    .NUM_CNT_BITS(4),
    .NUM_PS_BITS (4)
  ) dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .clear          (clear),
    .load           (load),
    .load_val       (load_val),
    .count_enable   (count_enable),
    .dir            (dir),
    .mode           (mode),
    .rollover_val   (rollover_val),
    .prescale_val   (prescale_val),
    .count_out      (count_out),
    .rollover_flag  (rollover_flag),
    .rollover_pulse (rollover_pulse),
    .done           (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: every clock edge presents a new output; pop the matching expectation.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      n_tests++;
      if ({count_out, rollover_flag, rollover_pulse, done} !==
          {mon_e.c, mon_e.f, mon_e.p, mon_e.d}) begin
        n_fail++;
        $display("FAIL %s: got count=%0d flag=%0b pulse=%0b done=%0b, expected count=%0d flag=%0b pulse=%0b done=%0b",
                 mon_e.name, count_out, rollover_flag, rollover_pulse, done,
                 mon_e.c, mon_e.f, mon_e.p, mon_e.d);
      end
    end
  end

  task automatic cyc(input string nm, input logic cl, input logic ld, input logic [3:0] lv,
                     input logic en, input logic [3:0] ec, input logic ef, input logic ep,
                     input logic ed);
    exp_t e;
    clear        = cl;
    load         = ld;
    load_val     = lv;
    count_enable = en;
    e.c = ec; e.f = ef; e.p = ep; e.d = ed; e.name = nm;
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic chk_now(input string nm, input logic [3:0] ec, input logic ef,
                         input logic ep, input logic ed);
    n_tests++;
    if ({count_out, rollover_flag, rollover_pulse, done} !== {ec, ef, ep, ed}) begin
      n_fail++;
      $display("FAIL %s: got count=%0d flag=%0b pulse=%0b done=%0b, expected count=%0d flag=%0b pulse=%0b done=%0b",
               nm, count_out, rollover_flag, rollover_pulse, done, ec, ef, ep, ed);
    end
  endtask

  initial begin
    n_rst = 1'b1; clear = 1'b0; load = 1'b0; load_val = '0; count_enable = 1'b0;
    dir = DIR_UP; mode = WRAP_ONE; rollover_val = 4'd5; prescale_val = 4'd0;
    #1 n_rst = 1'b0;
    #2 chk_now("reset_state", 4'd0, 1'b0, 1'b0, 1'b0);
    #19 n_rst = 1'b1;
    @(posedge clk);
    #2;

    // Up WRAP_ONE, rollover 5: 0,1..5,1,2,3
    cyc("wrap1_clear", 1, 0, 0, 0, 4'd0, 0, 0, 0);
    cyc("wrap1_1", 0, 0, 0, 1, 4'd1, 0, 0, 0);
    cyc("wrap1_2", 0, 0, 0, 1, 4'd2, 0, 0, 0);
    cyc("wrap1_3", 0, 0, 0, 1, 4'd3, 0, 0, 0);
    cyc("wrap1_4", 0, 0, 0, 1, 4'd4, 0, 0, 0);
    cyc("wrap1_5", 0, 0, 0, 1, 4'd5, 1, 1, 0);
    cyc("wrap1_r1", 0, 0, 0, 1, 4'd1, 0, 0, 0);
    cyc("wrap1_r2", 0, 0, 0, 1, 4'd2, 0, 0, 0);
    cyc("wrap1_r3", 0, 0, 0, 1, 4'd3, 0, 0, 0);
    cyc("wrap1_hold", 0, 0, 0, 0, 4'd3, 0, 0, 0);

    // Down WRAP_ZERO from 3, restart at 7
    dir = DIR_DOWN; mode = WRAP_ZERO; rollover_val = 4'd7;
    cyc("down_load", 0, 1, 4'd3, 0, 4'd3, 0, 0, 0);
    cyc("down_2", 0, 0, 0, 1, 4'd2, 0, 0, 0);
    cyc("down_1", 0, 0, 0, 1, 4'd1, 0, 0, 0);
    cyc("down_0", 0, 0, 0, 1, 4'd0, 1, 1, 0);
    cyc("down_7", 0, 0, 0, 1, 4'd7, 0, 0, 0);
    cyc("down_6", 0, 0, 0, 1, 4'd6, 0, 0, 0);

    // Up ONESHOT, rollover 4, one advance every 3 enabled cycles
    dir = DIR_UP; mode = ONESHOT; rollover_val = 4'd4; prescale_val = 4'd2;
    cyc("os_clear", 1, 0, 0, 0, 4'd0, 0, 0, 0);
    for (int i = 1; i <= 12; i++) begin
      cyc("oneshot", 0, 0, 0, 1, 4'(i / 3), i == 12, i == 12, i == 12);
    end
    for (int i = 0; i < 4; i++) begin
      cyc("os_held", 0, 0, 0, 1, 4'd4, 1, 0, 1);
    end
    cyc("os_clear2", 1, 0, 0, 1, 4'd0, 0, 0, 0);

    // Up SATURATE, rollover 3
    mode = SATURATE; rollover_val = 4'd3; prescale_val = 4'd0;
    cyc("sat_clear", 1, 0, 0, 0, 4'd0, 0, 0, 0);
    cyc("sat_1", 0, 0, 0, 1, 4'd1, 0, 0, 0);
    cyc("sat_2", 0, 0, 0, 1, 4'd2, 0, 0, 0);
    cyc("sat_3", 0, 0, 0, 1, 4'd3, 1, 1, 0);
    cyc("sat_hold_a", 0, 0, 0, 1, 4'd3, 1, 0, 0);
    cyc("sat_hold_b", 0, 0, 0, 1, 4'd3, 1, 0, 0);
    cyc("sat_hold_c", 0, 0, 0, 1, 4'd3, 1, 0, 0);

    // Priority clear > load > tick, then load above rollover wraps through 0
    mode = WRAP_ONE; rollover_val = 4'd5;
    cyc("prio_clear", 1, 0, 0, 0, 4'd0, 0, 0, 0);
    cyc("prio_1", 0, 0, 0, 1, 4'd1, 0, 0, 0);
    cyc("prio_2", 0, 0, 0, 1, 4'd2, 0, 0, 0);
    cyc("prio_all", 1, 1, 4'd9, 1, 4'd0, 0, 0, 0);
    cyc("load_9", 0, 1, 4'd9, 1, 4'd9, 0, 0, 0);
    for (int i = 1; i <= 12; i++) begin
      logic [3:0] v;
      v = 4'(9 + i);
      cyc("load_wrap", 0, 0, 0, 1, v, v == 4'd5, v == 4'd5, 0);
    end
    cyc("load_wrap_r1", 0, 0, 0, 1, 4'd1, 0, 0, 0);
    cyc("load_at_term", 0, 1, 4'd5, 0, 4'd5, 1, 0, 0);

    // Async reset with count=6, ps=1, done=1
    mode = ONESHOT; rollover_val = 4'd6; prescale_val = 4'd0;
    cyc("pre_rst_load", 0, 1, 4'd5, 0, 4'd5, 0, 0, 0);
    cyc("pre_rst_done", 0, 0, 0, 1, 4'd6, 1, 1, 1);
    cyc("pre_rst_ps1", 0, 0, 0, 1, 4'd6, 1, 0, 1);
    count_enable = 1'b0;
    #3 n_rst = 1'b0;
    #1 chk_now("async_rst", 4'd0, 1'b0, 1'b0, 1'b0);
    mode = WRAP_ONE; rollover_val = 4'd5;
    #2 n_rst = 1'b1;
    @(posedge clk);
    #2;
    cyc("post_rst_hold", 0, 0, 0, 0, 4'd0, 0, 0, 0);
    cyc("post_rst_1", 0, 0, 0, 1, 4'd1, 0, 0, 0);
    cyc("post_rst_2", 0, 0, 0, 1, 4'd2, 0, 0, 0);

    count_enable = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
